// File: rtl/rr_onehot_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_onehot_arbiter_if
// Bundles the request / grant / handshake signals of rr_onehot_arbiter.
//
// Parameters:
//   NUM_REQ  number of requesters (1..256); IDX_W is derived from it.
//
// Signals:
//   req_i    request vector, bit i = requester i wants service
//   gnt_o    one-hot grant, all-zero when nothing is granted
//   idx_o    binary index of the granted requester, 0 when gnt_o == 0
//   valid_o  a grant is presented downstream
//   ready_i  downstream accepts the current grant
//
// Modports:
//   master   the side that drives requests and ready (requesters + consumer)
//   slave    the arbiter itself
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface rr_onehot_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDX_W = (NUM_REQ == 1) ? 1 : $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req_i;
  logic [NUM_REQ-1:0] gnt_o;
  logic [IDX_W-1:0]   idx_o;
  logic               valid_o;
  logic               ready_i;

  modport master (
    output req_i,
    output ready_i,
    input  gnt_o,
    input  idx_o,
    input  valid_o
  );

  modport slave (
    input  req_i,
    input  ready_i,
    output gnt_o,
    output idx_o,
    output valid_o
  );
endinterface

// File: rtl/rr_onehot_arbiter.sv
// ---------------------------------------------------------------------------
// rr_onehot_arbiter
// Round-robin arbiter over NUM_REQ request lines with a valid/ready output
// handshake. The grant is presented both one-hot and as a binary index; the
// index comes from the onehot_to_bin encoder instantiated inside.
// Fairness comes from a registered priority pointer that only moves when a
// grant is actually accepted downstream.
//
// Ports:
//   clk_i    clock, all state updates on the rising edge
//   rst_ni   asynchronous active-low reset, all state cleared to 0
//   flush_i  synchronous clear of the priority pointer (and the lock)
//   bus      rr_onehot_arbiter_if.slave: req_i, gnt_o, idx_o, valid_o, ready_i
//
// Optional feature:
//   RR_ONEHOT_ARBITER_LOCK_EN  when defined, a stalled grant is locked so the
//                              output stays stable until it is accepted.
// Simulation checks are removed by defining COMMON_CELLS_ASSERTS_OFF.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module onehot_to_bin #(
  parameter int ONEHOT_W = 4,
  parameter int BIN_W    = (ONEHOT_W == 1) ? 1 : $clog2(ONEHOT_W)
) (
  input  logic [ONEHOT_W-1:0] onehot,
  output logic [BIN_W-1:0]    bin
);

  // OR together the indices of all set bits; for a one-hot (or zero) input
  // this is exactly the position of the set bit (or 0).
  always_comb begin
    bin = '0;
    for (int i = 0; i < ONEHOT_W; i++) begin
      if (onehot[i]) begin
        bin = bin | BIN_W'(i);
      end
    end
  end

endmodule

module rr_onehot_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  rr_onehot_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ == 1) ? 1 : $clog2(NUM_REQ);

  logic [IDX_W-1:0]   prio_q;
  logic [IDX_W-1:0]   prio_d;
  logic [IDX_W-1:0]   sel;
  logic [IDX_W-1:0]   sel_hi;
  logic [IDX_W-1:0]   sel_lo;
  logic               found_hi;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   next_ptr;
  logic               any_req;
  logic               valid;
  logic               xfer;
  logic [NUM_REQ-1:0] gnt;

  assign any_req = |bus.req_i;

  // Two candidates are searched in one descending sweep: the lowest request
  // at or above the pointer, and the lowest request overall. The second one
  // is the wrap-around choice when nothing sits at or above the pointer.
  always_comb begin
    found_hi = 1'b0;
    sel_hi   = '0;
    sel_lo   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_i[i]) begin
        sel_lo = IDX_W'(i);
        if (IDX_W'(i) >= prio_q) begin
          found_hi = 1'b1;
          sel_hi   = IDX_W'(i);
        end
      end
    end
    sel = found_hi ? sel_hi : sel_lo;
  end

`ifdef RR_ONEHOT_ARBITER_LOCK_EN
  logic             lock_q;
  logic             lock_d;
  logic [IDX_W-1:0] lock_idx_q;
  logic [IDX_W-1:0] lock_idx_d;

  assign grant_idx = lock_q ? lock_idx_q : sel;
  assign valid     = lock_q | any_req;

  // A presented but unaccepted grant gets frozen so downstream sees a stable
  // valid/grant pair. The lock is released by the accepting cycle or a flush.
  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (flush_i) begin
      lock_d = 1'b0;
    end else if (valid && !bus.ready_i) begin
      lock_d     = 1'b1;
      lock_idx_d = grant_idx;
    end else if (xfer) begin
      lock_d = 1'b0;
    end
  end

  // Lock state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end
`else
  assign grant_idx = sel;
  assign valid     = any_req;
`endif

  assign xfer = valid & bus.ready_i;
  assign gnt  = valid ? (NUM_REQ'(1) << grant_idx) : '0;

  // The pointer wraps explicitly at NUM_REQ-1 so non power-of-two sizes
  // never land on a non-existent requester. With one requester it stays 0.
  always_comb begin
    next_ptr = '0;
    if (NUM_REQ > 1 && int'(grant_idx) != NUM_REQ - 1) begin
      next_ptr = grant_idx + IDX_W'(1);
    end
  end

  // Flush wins over an accepted grant in the same cycle.
  always_comb begin
    prio_d = prio_q;
    if (flush_i) begin
      prio_d = '0;
    end else if (xfer) begin
      prio_d = next_ptr;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= '0;
    end else begin
      prio_q <= prio_d;
    end
  end

  onehot_to_bin #(
    .ONEHOT_W (NUM_REQ),
    .BIN_W    (IDX_W)
  ) u_enc (
    .onehot (gnt),
    .bin    (bus.idx_o)
  );

  assign bus.gnt_o   = gnt;
  assign bus.valid_o = valid;

`ifndef COMMON_CELLS_ASSERTS_OFF
  gnt_onehot_a: assert property (@(posedge clk_i) $onehot0(bus.gnt_o));
  idx_match_a: assert property (@(posedge clk_i)
    (bus.gnt_o == (bus.valid_o ? (NUM_REQ'(1) << bus.idx_o) : '0)) &&
    (bus.valid_o || bus.idx_o == '0));
`endif

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_onehot_arbiter
// Self-checking bench for rr_onehot_arbiter. Two instances are exercised, a
// power-of-two one (NUM_REQ=4) and a non power-of-two one (NUM_REQ=5).
// A behavioural model picks the winner by scanning requesters in circular
// order from the pointer; a compare process checks every cycle, and the
// directed sections pin hand-computed literal grants.
// Honours RR_ONEHOT_ARBITER_LOCK_EN the same way the design does.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_rr_onehot_arbiter;

`ifdef RR_ONEHOT_ARBITER_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic flush4 = 1'b0;
  logic flush5 = 1'b0;

  int checkCount = 0;
  int passCount  = 0;

  int mPrio    [2];
  bit mLock    [2];
  int mLockIdx [2];

  rr_onehot_arbiter_if #(.NUM_REQ(4)) bus4 ();
  rr_onehot_arbiter_if #(.NUM_REQ(5)) bus5 ();

  rr_onehot_arbiter #(.NUM_REQ(4)) dut4 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush4),
    .bus     (bus4.slave)
  );

  rr_onehot_arbiter #(.NUM_REQ(5)) dut5 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush5),
    .bus     (bus5.slave)
  );

  always #5 clk = ~clk;

  function automatic int numReq(input int d);
    return (d == 0) ? 4 : 5;
  endfunction

  function automatic logic [7:0] reqOf(input int d);
    return (d == 0) ? {4'b0, bus4.req_i} : {3'b0, bus5.req_i};
  endfunction

  function automatic logic readyOf(input int d);
    return (d == 0) ? bus4.ready_i : bus5.ready_i;
  endfunction

  function automatic logic flushOf(input int d);
    return (d == 0) ? flush4 : flush5;
  endfunction

  // Circular scan starting at the pointer; -1 means nobody is requesting.
  function automatic int modelSel(input int n, input int prio, input logic [7:0] req);
    for (int k = 0; k < n; k++) begin
      if (req[(prio + k) % n]) return (prio + k) % n;
    end
    return -1;
  endfunction

  function automatic int expGrant(input int d, input logic [7:0] req);
    if (mLock[d]) return mLockIdx[d];
    return modelSel(numReq(d), mPrio[d], req);
  endfunction

  // Model state advances on each rising edge from the inputs seen there.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        mPrio[d]    <= 0;
        mLock[d]    <= 1'b0;
        mLockIdx[d] <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (flushOf(d)) begin
          mPrio[d] <= 0;
          mLock[d] <= 1'b0;
        end else if (expGrant(d, reqOf(d)) >= 0 && readyOf(d)) begin
          mLock[d] <= 1'b0;
          mPrio[d] <= (expGrant(d, reqOf(d)) + 1) % numReq(d);
        end else if (expGrant(d, reqOf(d)) >= 0 && LOCK_EN) begin
          mLock[d]    <= 1'b1;
          mLockIdx[d] <= expGrant(d, reqOf(d));
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  task automatic compareDut(input int d);
    int g;
    logic [31:0] actGnt;
    logic [31:0] actIdx;
    logic [31:0] actValid;
    g = expGrant(d, reqOf(d));
    actGnt   = (d == 0) ? 32'(bus4.gnt_o)   : 32'(bus5.gnt_o);
    actIdx   = (d == 0) ? 32'(bus4.idx_o)   : 32'(bus5.idx_o);
    actValid = (d == 0) ? 32'(bus4.valid_o) : 32'(bus5.valid_o);
    checkOutput($sformatf("model_gnt_n%0d", numReq(d)), actGnt,
                (g >= 0) ? (32'd1 << g) : 32'd0);
    checkOutput($sformatf("model_idx_n%0d", numReq(d)), actIdx,
                (g >= 0) ? 32'(g) : 32'd0);
    checkOutput($sformatf("model_valid_n%0d", numReq(d)), actValid,
                (g >= 0) ? 32'd1 : 32'd0);
  endtask

  // Every falling edge, both instances are compared against the model.
  always @(negedge clk) begin
    compareDut(0);
    compareDut(1);
  end

  // Drive a new input set just after a rising edge, then return shortly
  // after the following falling edge so callers can check literal values.
  task automatic applyStimulus(input logic [3:0] r4, input logic rd4, input logic f4,
                               input logic [4:0] r5, input logic rd5, input logic f5);
    @(posedge clk);
    #2;
    bus4.req_i   = r4;
    bus4.ready_i = rd4;
    flush4       = f4;
    bus5.req_i   = r5;
    bus5.ready_i = rd5;
    flush5       = f5;
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] seq4 [5];
    seq4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    bus4.req_i   = '0;
    bus4.ready_i = 1'b0;
    bus5.req_i   = '0;
    bus5.ready_i = 1'b0;

    // Reset values, then grant while still held in reset.
    applyStimulus(4'b0000, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
    checkOutput("rst_valid", 32'(bus4.valid_o), 32'd0);
    checkOutput("rst_gnt",   32'(bus4.gnt_o),   32'd0);
    checkOutput("rst_idx",   32'(bus4.idx_o),   32'd0);
    applyStimulus(4'b1111, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
    checkOutput("rst_all_gnt", 32'(bus4.gnt_o), 32'b0001);
    checkOutput("rst_all_idx", 32'(bus4.idx_o), 32'd0);

    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Full request with ready held high rotates through all requesters.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b1111, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0);
      checkOutput("rr_seq_gnt", 32'(bus4.gnt_o), 32'(seq4[k]));
      checkOutput("rr_seq_idx", 32'(bus4.idx_o), 32'(k % 4));
    end

    // Five requesters: walk the pointer to 4, then check the wrap.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b0000, 1'b0, 1'b0, 5'b11111, 1'b1, 1'b0);
      checkOutput("n5_walk_idx", 32'(bus5.idx_o), 32'(k));
    end
    applyStimulus(4'b0000, 1'b0, 1'b0, 5'b00011, 1'b1, 1'b0);
    checkOutput("n5_wrap_gnt", 32'(bus5.gnt_o), 32'b00001);
    applyStimulus(4'b0000, 1'b0, 1'b0, 5'b00011, 1'b1, 1'b0);
    checkOutput("n5_after_wrap_gnt", 32'(bus5.gnt_o), 32'b00010);
    checkOutput("n5_after_wrap_idx", 32'(bus5.idx_o), 32'd1);

    // Stall holds the pointer; acceptance moves it on.
    applyStimulus(4'b0000, 1'b0, 1'b1, 5'b00000, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0101, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
      checkOutput("stall_gnt", 32'(bus4.gnt_o), 32'b0001);
    end
    applyStimulus(4'b0101, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0);
    checkOutput("stall_accept_gnt", 32'(bus4.gnt_o), 32'b0001);
    applyStimulus(4'b0101, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
    checkOutput("stall_next_gnt", 32'(bus4.gnt_o), 32'b0100);
    checkOutput("stall_next_idx", 32'(bus4.idx_o), 32'd2);

    // Flush beats a simultaneous transfer of requester 2.
    applyStimulus(4'b0000, 1'b0, 1'b1, 5'b00000, 1'b0, 1'b0);
    applyStimulus(4'b1111, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0);
    applyStimulus(4'b1111, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0);
    applyStimulus(4'b1111, 1'b1, 1'b1, 5'b00000, 1'b0, 1'b0);
    checkOutput("flush_cur_gnt", 32'(bus4.gnt_o), 32'b0100);
    applyStimulus(4'b1111, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
    checkOutput("flush_next_gnt", 32'(bus4.gnt_o), 32'b0001);

    // Request change while stalled.
    applyStimulus(4'b0000, 1'b0, 1'b1, 5'b00000, 1'b0, 1'b0);
    applyStimulus(4'b0010, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
    checkOutput("chg_first_gnt", 32'(bus4.gnt_o), 32'b0010);
`ifdef RR_ONEHOT_ARBITER_LOCK_EN
    for (int k = 0; k < 2; k++) begin
      applyStimulus(4'b1000, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
      checkOutput("lock_hold_gnt",   32'(bus4.gnt_o),   32'b0010);
      checkOutput("lock_hold_valid", 32'(bus4.valid_o), 32'd1);
    end
    applyStimulus(4'b1000, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0);
    checkOutput("lock_accept_gnt", 32'(bus4.gnt_o), 32'b0010);
    applyStimulus(4'b1000, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
    checkOutput("lock_after_gnt", 32'(bus4.gnt_o), 32'b1000);
`else
    applyStimulus(4'b1000, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
    checkOutput("nolock_chg_gnt", 32'(bus4.gnt_o), 32'b1000);
    checkOutput("nolock_chg_idx", 32'(bus4.idx_o), 32'd3);
    applyStimulus(4'b0000, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
    checkOutput("nolock_drop_valid", 32'(bus4.valid_o), 32'd0);
    checkOutput("nolock_drop_gnt",   32'(bus4.gnt_o),   32'd0);
`endif

    // Randomised traffic; the per-cycle compare process does the checking.
    for (int k = 0; k < 400; k++) begin
      applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 19) == 0),
                    5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 19) == 0));
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- Round-robin arbiter over NUM_REQ request lines with a valid/ready output handshake.
- Produces the grant both as a one-hot vector and as a binary index; the binary index comes from the team's one-hot-to-binary encoder instantiated internally.
- Sits directly upstream of one-hot consumers (mux selects, crossbar ports) and of binary-index consumers (address/ID fields).
- Fairness is maintained by a registered priority pointer that advances only on a completed handshake.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 1..256.
- IDX_W, NUM_REQ==1 ? 1 : $clog2(NUM_REQ), index width; derived, do not override.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous clear of priority pointer (and lock, if compiled in).
- req_i  in  NUM_REQ  request vector; bit i = requester i wants service.
- gnt_o  out  NUM_REQ  one-hot grant; all-zero when nothing is granted.
- idx_o  out  IDX_W  binary index of the granted requester; 0 when gnt_o==0.
- valid_o  out  1  a grant is presented downstream.
- ready_i  in  1  downstream accepts the current grant.

Behaviour:
- State:
  - prio_q[IDX_W-1:0]: lowest index holding highest priority.
  - lock_q and lock_idx_q: exist only with the optional feature.
  - All state resets to 0 asynchronously on rst_ni low.
  - Reset release is synchronous to clk_i.
- Selection (combinational, zero latency from req_i):
  - sel = lowest i >= prio_q with req_i[i]=1.
  - If no such i, sel = lowest i with req_i[i]=1 (wrap-around).
- Outputs:
  - valid_o = |req_i.
  - gnt_o = 1<<sel when valid_o, else 0.
  - idx_o = binary(gnt_o).
- gnt_o is at most one-hot in every cycle, including while in reset.
- Reset values: with req_i==0, valid_o=0, gnt_o=0, idx_o=0. During reset prio_q=0, so requester 0 has top priority.
- Handshake:
  - Transfer when valid_o && ready_i.
  - On a transfer, prio_q <= (sel==NUM_REQ-1) ? 0 : sel+1.
  - Otherwise prio_q holds.
  - ready_i may be asserted before valid_o; ready_i without valid_o has no effect.
- flush_i:
  - prio_q <= 0 next cycle; takes precedence over a simultaneous transfer update.
  - Does not mask outputs in the current cycle.
- NUM_REQ==1: prio_q is held at 0; gnt_o=req_i; idx_o=0.
- NUM_REQ not a power of two: prio_q never exceeds NUM_REQ-1. Wrap is explicit, never by natural overflow.
- Simultaneous requests: exactly one is granted per the pointer order; the others wait without starvation. A continuously asserted request is served within NUM_REQ transfers.
- Simulation-only check (disable with COMMON_CELLS_ASSERTS_OFF):
  - $onehot0(gnt_o) every cycle.
  - idx_o consistent with gnt_o.

Optional Feature:
- Macro: RR_ONEHOT_ARBITER_LOCK_EN.
- With the macro (grant lock):
  - When valid_o && !ready_i, set lock_q=1 and lock_idx_q=sel.
  - While lock_q=1: gnt_o = 1<<lock_idx_q and valid_o=1, regardless of req_i or prio_q. This keeps the output AXI-stable.
  - lock_q clears on the transfer cycle; prio_q then advances from lock_idx_q.
  - flush_i clears lock_q.
- Without the macro:
  - No lock state; selection may change while stalled if req_i changes.
  - valid_o may drop if req_i drops.

Test Plan:
- Reset, req_i=0 -> valid_o=0, gnt_o=0, idx_o=0. Hold rst_ni=0 with req_i=4'b1111 -> gnt_o=4'b0001, idx_o=0.
- NUM_REQ=4, req_i=4'b1111, ready_i=1 for 5 cycles -> gnt_o sequence 0001,0010,0100,1000,0001 and idx_o 0,1,2,3,0.
- NUM_REQ=5, prio_q=4, req_i=5'b00011 -> gnt_o=00001 (wrap). After transfer, prio_q=1 -> next gnt_o=00010.
- req_i=4'b0101, ready_i=0 for 3 cycles -> gnt_o stays 0001 and prio_q stays 0. Then ready_i=1 -> next gnt_o=0100.
- prio_q=2, flush_i=1 together with a transfer of sel=2 -> prio_q=0, not 3. Next with req_i=1111 -> gnt_o=0001.
- LOCK_EN only: grant 0010 stalled, req_i changes 0010->1000 -> gnt_o stays 0010 with valid_o=1 until ready_i. Then prio_q=2 and gnt_o=1000.
